// File: rtl/gray_cnt_arbiter_pkg.sv
// Shared types, default parameters and the Gray-code helper for gray_cnt_arbiter.
package gray_cnt_arbiter_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_CBITS = 18;
    localparam int DEF_LBITS = 8;
    localparam int MAX_CBITS = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Works on a fixed 32-bit container; callers zero-extend and truncate.
    function automatic logic [MAX_CBITS-1:0] bin2gray(input logic [MAX_CBITS-1:0] x);
        return x ^ (x >> 1);
    endfunction

endpackage

// File: rtl/gray_cnt_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above the pointer, modulo NREQ.
module gray_cnt_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   idx,
    output logic            any
);

    // Scan offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        int j;
        win = '0;
        idx = '0;
        any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req[j]) begin
                win    = '0;
                win[j] = 1'b1;
                idx    = PW'(j);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gray_cnt_arbiter.sv
// Round-robin arbiter owning a shared Gray-coded counter; one window of len+1 counts per grant.
// Optional formal properties are compiled in with GRAY_CNT_ARBITER_LIVENESS_EN.
module gray_cnt_arbiter
    import gray_cnt_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int CBITS = DEF_CBITS,
    parameter int LBITS = DEF_LBITS,
    parameter int PW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LBITS-1:0] len,
    output logic [NREQ-1:0]       grant,
    output logic [PW-1:0]         owner,
    output logic                  busy,
    output logic [CBITS-1:0]      gray_c,
    output logic                  sig,
    output logic [NREQ-1:0]       done
);

    state_t           state;
    logic [CBITS-1:0] cnt;
    logic [LBITS-1:0] rem;
    logic [PW-1:0]    ptr;

    logic [NREQ-1:0]      pick_win;
    logic [PW-1:0]        pick_idx;
    logic                 pick_any;
    logic [MAX_CBITS-1:0] gray_full;

    gray_cnt_arbiter_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .win (pick_win),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            done  <= '0;
            cnt   <= '0;
            rem   <= '0;
            ptr   <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant <= pick_win;
                        owner <= pick_idx;
                        rem   <= len[pick_idx*LBITS +: LBITS];
                        ptr   <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
                        state <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + CBITS'(1);
                    // Last count of the window: release and flag the owner next cycle.
                    if (rem == '0) begin
                        grant <= '0;
                        owner <= '0;
                        done  <= grant;
                        state <= IDLE;
                    end else begin
                        rem <= rem - LBITS'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = |grant;
    assign gray_full = bin2gray(MAX_CBITS'(cnt));
    assign gray_c    = busy ? gray_full[CBITS-1:0] : '0;
    assign sig       = busy & (cnt == '0);

`ifdef GRAY_CNT_ARBITER_LIVENESS_EN
    a_grant_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));
    a_busy_grant   : assert property (@(posedge clk) disable iff (!rst) busy == (|grant));
    a_sig_busy     : assert property (@(posedge clk) disable iff (!rst) sig |-> busy);
    c_sig          : cover property (@(posedge clk) disable iff (!rst) sig);

    for (genvar i = 0; i < NREQ; i++) begin : g_live
        a_req_granted : assert property (@(posedge clk) disable iff (!rst)
            req[i] |-> s_eventually grant[i]);
        a_grant_done  : assert property (@(posedge clk) disable iff (!rst)
            grant[i] |-> s_eventually done[i]);
    end
`endif

endmodule

// File: tb/tb_gray_cnt_arbiter.sv
// Directed self-checking bench for gray_cnt_arbiter (default build plus a CBITS=4 wrap instance).
module tb_gray_cnt_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] len;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        busy;
    logic [17:0] gray_c;
    logic        sig;
    logic [3:0]  done;

    logic        w_rst;
    logic [3:0]  w_req;
    logic [15:0] w_len;
    logic [3:0]  w_grant;
    logic [1:0]  w_owner;
    logic        w_busy;
    logic [3:0]  w_gray_c;
    logic        w_sig;
    logic [3:0]  w_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gray_cnt_arbiter dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .len    (len),
        .grant  (grant),
        .owner  (owner),
        .busy   (busy),
        .gray_c (gray_c),
        .sig    (sig),
        .done   (done)
    );

    gray_cnt_arbiter #(.NREQ(4), .CBITS(4), .LBITS(4)) u_wrap (
        .clk    (clk),
        .rst    (w_rst),
        .req    (w_req),
        .len    (w_len),
        .grant  (w_grant),
        .owner  (w_owner),
        .busy   (w_busy),
        .gray_c (w_gray_c),
        .sig    (w_sig),
        .done   (w_done)
    );

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] l);
        req = r;
        len = l;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst   = 1'b0;
        w_rst = 1'b0;
        w_req = '0;
        w_len = '0;
        applyStimulus(4'b1111, 32'h0);

        // Reset holds everything idle even with every request up.
        tick();
        tick();
        checkOutput("rst_grant", 32'(grant), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_gray", 32'(gray_c), 32'h0);
        checkOutput("rst_sig", 32'(sig), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_owner", 32'(owner), 32'h0);
        applyStimulus(4'b0000, 32'h0);
        rst   = 1'b1;
        w_rst = 1'b1;
        tick();
        checkOutput("idle_grant", 32'(grant), 32'h0);

        // Single request, len=3: four window cycles, gray 0,1,3,2.
        applyStimulus(4'b0100, 32'h0003_0000);
        tick();
        applyStimulus(4'b0000, 32'h0003_0000);
        checkOutput("single_grant", 32'(grant), 32'h4);
        checkOutput("single_owner", 32'(owner), 32'h2);
        checkOutput("single_gray0", 32'(gray_c), 32'h0);
        checkOutput("single_sig0", 32'(sig), 32'h1);
        tick();
        checkOutput("single_gray1", 32'(gray_c), 32'h1);
        checkOutput("single_sig1", 32'(sig), 32'h0);
        tick();
        checkOutput("single_gray2", 32'(gray_c), 32'h3);
        tick();
        checkOutput("single_gray3", 32'(gray_c), 32'h2);
        checkOutput("single_grant3", 32'(grant), 32'h4);
        tick();
        checkOutput("single_done", 32'(done), 32'h4);
        checkOutput("single_end_grant", 32'(grant), 32'h0);
        checkOutput("single_end_gray", 32'(gray_c), 32'h0);
        checkOutput("single_end_owner", 32'(owner), 32'h0);
        tick();
        checkOutput("single_done_clr", 32'(done), 32'h0);

        // Round robin from reset with all lengths zero.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        applyStimulus(4'b1111, 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput($sformatf("rr_grant%0d", k), 32'(grant), 32'(4'b0001 << (k % 4)));
            checkOutput($sformatf("rr_owner%0d", k), 32'(owner), 32'(k % 4));
            if (k == 4) applyStimulus(4'b0000, 32'h0);
            tick();
            checkOutput($sformatf("rr_gap%0d", k), 32'(grant), 32'h0);
            checkOutput($sformatf("rr_done%0d", k), 32'(done), 32'(4'b0001 << (k % 4)));
        end
        tick();
        checkOutput("rr_idle", 32'(busy), 32'h0);

        // Withdrawn request and mid-window drop; counter sits at 5 here.
        applyStimulus(4'b0001, 32'h0000_0005);
        tick();
        checkOutput("mid_grant1", 32'(grant), 32'h1);
        checkOutput("mid_gray1", 32'(gray_c), 32'h7);
        tick();
        applyStimulus(4'b1001, 32'h0000_0005);
        tick();
        applyStimulus(4'b0000, 32'h0000_0000);
        checkOutput("mid_grant3", 32'(grant), 32'h1);
        tick();
        tick();
        tick();
        checkOutput("mid_grant6", 32'(grant), 32'h1);
        tick();
        checkOutput("mid_done", 32'(done), 32'h1);
        checkOutput("mid_end_grant", 32'(grant), 32'h0);
        tick();
        checkOutput("withdraw_grant", 32'(grant), 32'h0);
        tick();
        checkOutput("withdraw_grant2", 32'(grant), 32'h0);

        // Reset in cycle 2 of a len=10 window: no done, counter cleared.
        applyStimulus(4'b0100, 32'h000A_0000);
        tick();
        applyStimulus(4'b0000, 32'h0);
        checkOutput("rstmid_grant", 32'(grant), 32'h4);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checkOutput("rstmid_grant_clr", 32'(grant), 32'h0);
        checkOutput("rstmid_done", 32'(done), 32'h0);
        tick();
        checkOutput("rstmid_done2", 32'(done), 32'h0);
        applyStimulus(4'b0010, 32'h0);
        tick();
        applyStimulus(4'b0000, 32'h0);
        checkOutput("rstmid_regrant", 32'(grant), 32'h2);
        checkOutput("rstmid_cnt0_gray", 32'(gray_c), 32'h0);
        checkOutput("rstmid_cnt0_sig", 32'(sig), 32'h1);
        tick();
        tick();

        // CBITS=4 instance: advance counter to 14, then a len=3 window wraps.
        w_req = 4'b0001;
        w_len = 16'h000D;
        tick();
        w_req = 4'b0000;
        checkOutput("wrap_pre_grant", 32'(w_grant), 32'h1);
        for (int k = 0; k < 14; k++) tick();
        checkOutput("wrap_pre_done", 32'(w_done), 32'h1);
        w_req = 4'b0010;
        w_len = 16'h0030;
        tick();
        w_req = 4'b0000;
        checkOutput("wrap_grant", 32'(w_grant), 32'h2);
        checkOutput("wrap_gray14", 32'(w_gray_c), 32'h9);
        checkOutput("wrap_sig14", 32'(w_sig), 32'h0);
        tick();
        checkOutput("wrap_gray15", 32'(w_gray_c), 32'h8);
        checkOutput("wrap_sig15", 32'(w_sig), 32'h0);
        tick();
        checkOutput("wrap_gray0", 32'(w_gray_c), 32'h0);
        checkOutput("wrap_sig0", 32'(w_sig), 32'h1);
        tick();
        checkOutput("wrap_gray1", 32'(w_gray_c), 32'h1);
        checkOutput("wrap_sig1", 32'(w_sig), 32'h0);
        checkOutput("wrap_busy1", 32'(w_busy), 32'h1);
        tick();
        checkOutput("wrap_done", 32'(w_done), 32'h2);
        checkOutput("wrap_sig_idle", 32'(w_sig), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_cnt_arbiter.md
Name: gray_cnt_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one free-running CBITS-bit Gray-coded counter among NREQ requesters.
- Each requester asks for a counting window of programmable length. The block grants one requester at a time, advances the shared counter only while a window is active, and reports wrap (sig) and completion (done).
- Sits between the requester agents and the Gray counter datapath. It owns the counter register.

Parameters:
- NREQ, 4, number of requesters (2..8)
- CBITS, 18, width of the shared binary/Gray counter
- LBITS, 8, width of each requester's window-length field; LBITS <= CBITS

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous active-low reset
- req  input  NREQ  per-requester request level; hold until grant
- len  input  NREQ*LBITS  window length L for requester i in bits [i*LBITS +: LBITS]; window spans L+1 counts
- grant  output  NREQ  one-hot owner of current window; all-zero when idle
- owner  output  $clog2(NREQ)  index of the granted requester; 0 when idle
- busy  output  1  window active (|grant)
- gray_c  output  CBITS  cnt ^ (cnt >> 1) while busy; 0 when not busy
- sig  output  1  busy & (cnt == 0), i.e. the counter sits at its wrap point during a window
- done  output  NREQ  one-cycle pulse on the owner's bit after its window ends

Behaviour:
- Reset: rst==0 at a posedge forces:
  - state IDLE
  - grant=0, owner=0, busy=0, done=0
  - cnt=0, rem=0
  - rr pointer=0
- Reset overrides every other event. A window cut by reset produces no done.
- FSM states are IDLE and RUN.
- IDLE:
  - If any req is high, pick the first i with req[i]=1, scanning from the pointer upward modulo NREQ.
  - At the next posedge: grant[i]=1, owner=i, rem=len[i], pointer=(i+1)%NREQ, state=RUN.
  - Latency from req sampled high in IDLE to grant is 1 cycle.
- RUN:
  - Each posedge does cnt <= cnt+1, with wrap 2^CBITS-1 -> 0.
  - If rem==0 at the posedge: grant clears, done[owner] pulses for the following cycle, state=IDLE. Otherwise rem <= rem-1.
  - grant is therefore high for exactly L+1 cycles, and cnt advances L+1 times per window.
- cnt is never cleared between windows. It holds its value in IDLE, so timestamps stay continuous across owners.
- done cycle: the block is in IDLE and arbitrates in that same cycle. Back-to-back windows have exactly 1 idle cycle between them.
- req[i] dropped before grant: the request is withdrawn and never granted.
- req[i] dropped during the owner's window: ignored; the window runs to completion on the latched length.
- req[i] still high in the done cycle: treated as a new request. The pointer has moved past i, so other pending requesters win first.
- len is sampled only on the grant edge. Later changes have no effect on the current window.
- sig may pulse at most once per 2^CBITS window cycles. sig is 0 whenever busy=0.
- Fairness bound: a requester holding req is granted within (NREQ-1)*(2^LBITS+1) cycles.

Optional Feature:
- Macro GRAY_CNT_ARBITER_LIVENESS_EN.
- When defined, the module compiles in formal properties:
  - one-hot-or-zero grant
  - busy==|grant
  - sig implies busy
  - per requester: req[i] held -> s_eventually grant[i]
  - per requester: grant[i] -> s_eventually done[i]
  - with a cover on sig.
- When undefined, there are no properties and the RTL behaviour is identical.

Decomposition:
- Package gray_cnt_arbiter_pkg holds:
  - the state enum typedef (IDLE, RUN)
  - default parameter constants
  - a function bin2gray(x) = x ^ (x >> 1)
- One sub-module fits naturally: rr_pick, a pure combinational round-robin priority picker (req, pointer -> one-hot winner plus index).
- The counter and FSM stay in the top module.

Test Plan:
- Reset: rst=0 for 2 cycles with req=4'b1111 -> grant=0, busy=0, gray_c=0, sig=0, done=0.
- Single request: req[2]=1, len[2]=3 -> grant=4'b0100 one cycle later and held 4 cycles. gray_c steps 0,1,3,2 from cnt=0. done=4'b0100 for one cycle after.
- Round robin: req=4'b1111, all len=0 from reset -> grant order 0,1,2,3,0, each 1 cycle long with 1 idle cycle between.
- Wrap: CBITS=4, cnt pre-advanced to 14, req[1]=1, len[1]=3 -> cnt 14,15,0,1. sig=1 only in the third window cycle. gray_c=0 in that cycle.
- Withdraw and mid-window: req[3] pulses 1 cycle while req[0] owns -> req[3] never granted. Dropping req[0] mid-window leaves its window at full length with done[0] still asserted.
- Reset mid-window: rst=0 in cycle 2 of a len=10 window -> next cycle grant=0 and no done pulse. cnt=0 afterward.
